// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED colour-fade sequencer: FSM encodings,
// default field widths and the one-LSB-toward-target helper.
package led_ctrl_pkg;

  localparam int STEP_W_DEF = 16;
  localparam int HOLD_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FADE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Moves only toward the target, so the result can never wrap.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt)
      return cur + 8'd1;
    else if (cur > tgt)
      return cur - 8'd1;
    else
      return cur;
  endfunction

endpackage

// File: rtl/fade_channel.sv
// One colour channel: holds the current duty and nudges it one LSB toward
// the target whenever step_en is high.
module fade_channel
  import led_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step_en,
  input  logic [7:0] target,
  output logic [7:0] value,
  output logic       at_target
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  always_comb begin
    value_d = value_q;
    if (step_en)
      value_d = step_toward(value_q, target);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      value_q <= 8'd0;
    else
      value_q <= value_d;
  end

  assign value     = value_q;
  assign at_target = (value_q == target);

endmodule

// File: rtl/led_fade_ctrl.sv
// Colour-fade sequencer: accepts one command, ramps r/g/b toward the target
// once per step period, holds for the hold time, then pulses done.
module led_fade_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF,
  parameter int HOLD_W = HOLD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_r,
  input  logic [7:0]        cmd_g,
  input  logic [7:0]        cmd_b,
  input  logic [STEP_W-1:0] cmd_step,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              abort,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [7:0]        tgt_q [3];
  logic [7:0]        tgt_d [3];
  logic [STEP_W-1:0] step_rld_q, step_rld_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              done_q, done_d;

  logic [7:0]        cmd_col [3];
  logic [7:0]        val [3];
  logic [2:0]        at_tgt;
  logic              all_at;
  logic              step_en;
  logic [STEP_W-1:0] cmd_rld;

  assign cmd_col[0] = cmd_r;
  assign cmd_col[1] = cmd_g;
  assign cmd_col[2] = cmd_b;
  assign all_at     = &at_tgt;
  // A step period of 0 behaves like 1, so the reload value is max(step,1)-1.
  assign cmd_rld    = (cmd_step == '0) ? '0 : cmd_step - STEP_W'(1);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      fade_channel u_chan (
        .clk       (clk),
        .rst       (rst),
        .step_en   (step_en),
        .target    (tgt_q[gi]),
        .value     (val[gi]),
        .at_target (at_tgt[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < 3; i++) tgt_q[i] <= 8'd0;
      step_rld_q <= '0;
      step_cnt_q <= '0;
      hold_q     <= '0;
      hold_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      for (int i = 0; i < 3; i++) tgt_q[i] <= tgt_d[i];
      step_rld_q <= step_rld_d;
      step_cnt_q <= step_cnt_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_FADE;
      ST_FADE: begin
        if (abort)       state_d = ST_IDLE;
        else if (all_at) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (abort || hold_cnt_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: target/period latching, step and hold counters, done pulse.
  always_comb begin
    for (int i = 0; i < 3; i++) tgt_d[i] = tgt_q[i];
    step_rld_d = step_rld_q;
    step_cnt_d = step_cnt_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    done_d     = 1'b0;
    step_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          for (int i = 0; i < 3; i++) tgt_d[i] = cmd_col[i];
          hold_d     = cmd_hold;
          step_rld_d = cmd_rld;
          step_cnt_d = cmd_rld;
        end
      end
      ST_FADE: begin
        if (!abort) begin
          if (all_at) begin
            hold_cnt_d = hold_q;
          end else if (step_cnt_q == '0) begin
            step_en    = 1'b1;
            step_cnt_d = step_rld_q;
          end else begin
            step_cnt_d = step_cnt_q - STEP_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (!abort) begin
          if (hold_cnt_q == '0) done_d = 1'b1;
          else                  hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    cmd_ready = (state_q == ST_IDLE);
    done      = done_q;
    r         = val[0];
    g         = val[1];
    b         = val[2];
  end

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Directed bench for led_fade_ctrl: stimulus pushes expected completions into
// a scoreboard queue; a negedge monitor checks every done pulse against it.
module tb_led_fade_ctrl;

  localparam int STEP_W = 16;
  localparam int HOLD_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [7:0]        cmd_r = 8'd0;
  logic [7:0]        cmd_g = 8'd0;
  logic [7:0]        cmd_b = 8'd0;
  logic [STEP_W-1:0] cmd_step = '0;
  logic [HOLD_W-1:0] cmd_hold = '0;
  logic              abort = 1'b0;
  logic [7:0]        r, g, b;
  logic              busy, done;

  typedef struct {
    int r;
    int g;
    int b;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_cnt = 0;

  always #5 clk = ~clk;

  led_fade_ctrl #(.STEP_W(STEP_W), .HOLD_W(HOLD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_r     (cmd_r),
    .cmd_g     (cmd_g),
    .cmd_b     (cmd_b),
    .cmd_step  (cmd_step),
    .cmd_hold  (cmd_hold),
    .abort     (abort),
    .r         (r),
    .g         (g),
    .b         (b),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end else begin
      $display("[TB] ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: latency is counted in cycles from the handshake edge to the done cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    cyc_cnt++;
    if (done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no done");
      end else begin
        e = exp_q.pop_front();
        check("done_r", int'(r), e.r);
        check("done_g", int'(g), e.g);
        check("done_b", int'(b), e.b);
        check("done_latency", cyc_cnt, e.lat);
        check("done_with_ready", int'(cmd_ready), 1);
      end
    end
    if (cmd_valid && cmd_ready && !rst) cyc_cnt = 0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns at the first cycle after the handshake edge (FADE cycle 1).
  // Fields are scrambled afterwards to show they are sampled only at handshake.
  task automatic send(input int cr, input int cg, input int cb,
                      input int stp, input int hld, input logic ab);
    int n = 0;
    while (!cmd_ready && n < 1000) begin
      tick(1);
      n++;
    end
    if (!cmd_ready) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL send_timeout: cmd_ready got 0, expected 1");
    end
    cmd_r = 8'(cr); cmd_g = 8'(cg); cmd_b = 8'(cb);
    cmd_step = STEP_W'(stp); cmd_hold = HOLD_W'(hld);
    cmd_valid = 1'b1;
    abort = ab;
    tick(1);
    cmd_valid = 1'b0;
    abort = 1'b0;
    cmd_r = ~cmd_r; cmd_g = ~cmd_g; cmd_b = ~cmd_b;
    cmd_step = '1; cmd_hold = '1;
  endtask

  task automatic push_exp(input int er, input int eg, input int eb, input int lat);
    exp_t e;
    e.r = er; e.g = eg; e.b = eb; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      tick(1);
      n++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL idle_timeout: busy got 1, expected 0");
    end
    tick(2);
  endtask

  initial begin
    // Reset released mid-cycle.
    #23 rst = 1'b0;
    tick(2);
    check("reset_r", int'(r), 0);
    check("reset_g", int'(g), 0);
    check("reset_b", int'(b), 0);
    check("reset_ready", int'(cmd_ready), 1);
    check("reset_busy", int'(busy), 0);
    tick(3);

    // Basic fade: 3 steps of period 4, hold 2 -> latency 13 + 3 + 1.
    push_exp(3, 0, 0, 17);
    send(3, 0, 0, 4, 2, 1'b0);
    check("basic_busy", int'(busy), 1);
    tick(3);
    check("basic_r_c4", int'(r), 0);
    tick(1);
    check("basic_r_c5", int'(r), 1);
    tick(4);
    check("basic_r_c9", int'(r), 2);
    tick(4);
    check("basic_r_c13", int'(r), 3);
    wait_idle();

    // Step 0 behaves as 1: (3,0,0) -> (10,0,5), D=7.
    push_exp(10, 0, 5, 10);
    send(10, 0, 5, 0, 0, 1'b0);
    wait_idle();

    // Bidirectional: (10,0,5) -> (8,2,5), D=2.
    push_exp(8, 2, 5, 5);
    send(8, 2, 5, 0, 0, 1'b0);
    tick(1);
    check("bidir_r_c2", int'(r), 9);
    check("bidir_g_c2", int'(g), 1);
    check("bidir_b_c2", int'(b), 5);
    wait_idle();

    // No-op command: done on the 3rd cycle after handshake.
    push_exp(8, 2, 5, 3);
    send(8, 2, 5, 7, 0, 1'b0);
    check("noop_busy", int'(busy), 1);
    wait_idle();

    // Async reset during HOLD: outputs clear without a clock edge.
    send(20, 20, 20, 1, 50, 1'b0);
    tick(29);
    check("hold_busy_before_rst", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_r", int'(r), 0);
    check("arst_g", int'(g), 0);
    check("arst_b", int'(b), 0);
    check("arst_busy", int'(busy), 0);
    tick(2);
    #2 rst = 1'b0;
    tick(2);
    check("arst_ready", int'(cmd_ready), 1);

    // Abort in FADE of a 0->255 step-1 fade once r shows 6.
    send(255, 0, 0, 1, 0, 1'b0);
    tick(6);
    check("abort_r_before", int'(r), 6);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_r_frozen", int'(r), 6);
    tick(3);
    check("abort_r_still", int'(r), 6);

    // New command fades from the frozen colour (6,0,0) -> (3,0,0), hold 1.
    push_exp(3, 0, 0, 7);
    send(3, 0, 0, 1, 1, 1'b0);
    tick(1);
    check("resume_r_c2", int'(r), 5);
    wait_idle();

    // Abort in IDLE is ignored and the same-cycle command is accepted.
    push_exp(6, 6, 6, 15);
    send(6, 6, 6, 2, 0, 1'b1);
    check("idle_abort_busy", int'(busy), 1);
    wait_idle();

    // Abort during HOLD: colour frozen, no done.
    send(9, 6, 6, 1, 5, 1'b0);
    tick(6);
    check("hold_abort_busy", int'(busy), 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("hold_abort_idle", int'(busy), 0);
    check("hold_abort_r", int'(r), 9);
    tick(10);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
